// File: rtl/uart_rx_controller.sv
// UART receive sequencer: start detect, oversampled bit timing, LSB-first shift, parity hand-off and host holding register.
// Optional parity stage enabled by defining UART_RX_PARITY_EN.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

module uart_rx_controller #(
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int OVERSAMPLE = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  baud_tick,
    input  logic                  rx_in,
    output logic                  parity_load,
    output logic                  parity_bit,
    output logic [DATA_WIDTH-1:0] shift_data,
    input  logic                  parity_bit_error,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ack,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overrun,
    output logic                  busy
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t state, state_nxt;

    logic          sync1, rx_s, rx_q;
    logic [TW-1:0] tcnt;
    logic [BW-1:0] bcnt;
    logic          mid_pt, bit_pt, fall, last_bit;
    logic          sample_data, par_sample, commit;
    logic          frame_par_err;

    assign mid_pt   = baud_tick && (tcnt == TW'(OVERSAMPLE/2 - 1));
    assign bit_pt   = baud_tick && (tcnt == TW'(OVERSAMPLE - 1));
    assign fall     = rx_q && !rx_s;
    assign last_bit = (bcnt == BW'(DATA_WIDTH - 1));

    // rx_q holds the previous rx_s so only a 1->0 transition starts a frame
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b1;
            rx_s  <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            sync1 <= rx_in;
            rx_s  <= sync1;
            rx_q  <= rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:   if (fall) state_nxt = START;
            START:  if (mid_pt) state_nxt = rx_s ? IDLE : DATA;
`ifdef UART_RX_PARITY_EN
            DATA:   if (bit_pt && last_bit) state_nxt = PARITY;
            PARITY: if (bit_pt) state_nxt = STOP;
`else
            DATA:   if (bit_pt && last_bit) state_nxt = STOP;
`endif
            STOP:   if (bit_pt) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy        = (state != IDLE);
        sample_data = (state == DATA) && bit_pt;
        par_sample  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_sample  = (state == PARITY) && bit_pt;
`endif
        commit      = (state == STOP) && bit_pt;
    end

    // tcnt restarts at the start-bit midpoint so later samples land mid-bit
    always_ff @(posedge clk) begin
        if (rst) begin
            tcnt <= '0;
            bcnt <= '0;
        end else begin
            if (state == IDLE || (state == START && mid_pt))
                tcnt <= '0;
            else if (baud_tick)
                tcnt <= (tcnt == TW'(OVERSAMPLE - 1)) ? '0 : tcnt + 1'b1;

            if (state != DATA)
                bcnt <= '0;
            else if (sample_data)
                bcnt <= last_bit ? '0 : bcnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)              shift_data <= '0;
        else if (sample_data) shift_data <= {rx_s, shift_data[DATA_WIDTH-1:1]};
    end

`ifdef UART_RX_PARITY_EN
    // checker result is only meaningful during the single parity_load clk
    always_ff @(posedge clk) begin
        if (rst) begin
            parity_load   <= 1'b0;
            parity_bit    <= 1'b0;
            frame_par_err <= 1'b0;
        end else begin
            parity_load <= par_sample;
            if (par_sample)  parity_bit    <= rx_s;
            if (parity_load) frame_par_err <= parity_bit_error;
        end
    end
`else
    logic unused_par;
    assign unused_par    = parity_bit_error | par_sample;
    assign parity_load   = 1'b0;
    assign parity_bit    = 1'b0;
    assign frame_par_err = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (commit) begin
                if (!rx_valid || rx_ack) begin
                    rx_data    <= shift_data;
                    parity_err <= frame_par_err;
                    frame_err  <= ~rx_s;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack && rx_valid) begin
                rx_valid   <= 1'b0;
                parity_err <= 1'b0;
                frame_err  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller: 4 clk per baud_tick, 16 ticks per bit.
module tb_uart_rx_controller;
`ifdef UART_RX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif

    logic       clk = 1'b0;
    logic       rst, baud_tick, rx_in, rx_ack;
    logic       parity_load, parity_bit, parity_bit_error;
    logic [7:0] shift_data, rx_data;
    logic       rx_valid, parity_err, frame_err, overrun, busy;

    logic [1:0] tdiv = 2'd0;
    int         pl_cnt = 0, ov_cnt = 0;
    logic [7:0] pl_data = 8'h00;
    int         n_assert = 0, n_fail = 0;

    uart_rx_controller #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .rx_in(rx_in),
        .parity_load(parity_load), .parity_bit(parity_bit), .shift_data(shift_data),
        .parity_bit_error(parity_bit_error), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ack(rx_ack), .parity_err(parity_err), .frame_err(frame_err),
        .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) tdiv <= tdiv + 2'd1;
    assign baud_tick = (tdiv == 2'd3);

    // odd-parity checker: error when the received bit equals the data XOR
    assign parity_bit_error = parity_load && (parity_bit == ^shift_data);

    always @(negedge clk) begin
        if (parity_load) begin
            pl_cnt  <= pl_cnt + 1;
            pl_data <= shift_data;
        end
        if (overrun) ov_cnt <= ov_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // returns #1 after the next posedge on which baud_tick was high
    task automatic wait_tick();
        @(negedge clk);
        while (!baud_tick) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        repeat (16) wait_tick();
    endtask

    task automatic send_frame(input logic [7:0] d, input logic par, input logic stop, input logic ack_commit);
        wait_tick();
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR == 1) send_bit(par);
        rx_in = stop;
        repeat (7) wait_tick();
        if (ack_commit) begin
            @(negedge clk);
            while (!baud_tick) @(negedge clk);
            rx_ack = 1'b1;
            @(posedge clk);
            #1;
            rx_ack = 1'b0;
        end else begin
            wait_tick();
        end
        repeat (8) wait_tick();
    endtask

    task automatic do_ack();
        rx_ack = 1'b1;
        @(posedge clk);
        #1;
        rx_ack = 1'b0;
    endtask

    function automatic logic odd_par(input logic [7:0] d);
        return ~^d;
    endfunction

    initial begin
        int   pl0, ov0;
        logic saw_busy;
        rst = 1'b1; rx_in = 1'b1; rx_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", rx_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data", rx_data, 0);
        check("rst_shift", shift_data, 0);
        check("rst_flags", {parity_load, parity_err, frame_err, overrun}, 0);
        rst = 1'b0;
        repeat (4) wait_tick();

        // short low glitch: START entered, rejected at the midpoint
        wait_tick();
        rx_in = 1'b0;
        repeat (2) wait_tick();
        check("glitch_start", busy, 1);
        repeat (2) wait_tick();
        rx_in = 1'b1;
        repeat (8) wait_tick();
        check("glitch_idle", busy, 0);
        check("glitch_valid", rx_valid, 0);

        pl0 = pl_cnt;
        send_frame(8'hA5, odd_par(8'hA5), 1'b1, 1'b0);
        check("a5_valid", rx_valid, 1);
        check("a5_data", rx_data, 8'hA5);
        check("a5_perr", parity_err, 0);
        check("a5_ferr", frame_err, 0);
        check("a5_pl_cnt", pl_cnt - pl0, PAR);
        check("a5_pl_data", pl_data, (PAR == 1) ? 8'hA5 : 8'h00);
        do_ack();
        check("a5_ack", rx_valid, 0);

        send_frame(8'hA5, 1'b0, 1'b1, 1'b0);
        check("a5bad_valid", rx_valid, 1);
        check("a5bad_perr", parity_err, PAR);
        do_ack();
        check("a5bad_ack_perr", parity_err, 0);

        send_frame(8'h3C, odd_par(8'h3C), 1'b0, 1'b0);
        check("brk_ferr", frame_err, 1);
        check("brk_data", rx_data, 8'h3C);
        saw_busy = 1'b0;
        repeat (48) begin
            wait_tick();
            if (busy) saw_busy = 1'b1;
        end
        check("brk_no_start", saw_busy, 0);
        rx_in = 1'b1;
        repeat (16) wait_tick();
        check("brk_high_idle", busy, 0);
        do_ack();
        check("brk_ack_ferr", frame_err, 0);
        check("brk_ack_valid", rx_valid, 0);

        ov0 = ov_cnt;
        send_frame(8'h11, odd_par(8'h11), 1'b1, 1'b0);
        send_frame(8'h22, odd_par(8'h22), 1'b1, 1'b0);
        check("ovr_data", rx_data, 8'h11);
        check("ovr_valid", rx_valid, 1);
        check("ovr_pulses", ov_cnt - ov0, 1);
        send_frame(8'h22, odd_par(8'h22), 1'b1, 1'b1);
        check("ackc_data", rx_data, 8'h22);
        check("ackc_valid", rx_valid, 1);
        check("ackc_no_ovr", ov_cnt - ov0, 1);

        // reset in the middle of data bit 4 with a frame still held
        wait_tick();
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        rx_in = 1'b0;
        repeat (8) wait_tick();
        rx_in = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_busy", busy, 0);
        check("mrst_valid", rx_valid, 0);
        check("mrst_data", rx_data, 0);
        check("mrst_shift", shift_data, 0);
        rst = 1'b0;
        repeat (32) wait_tick();
        send_frame(8'h5A, odd_par(8'h5A), 1'b1, 1'b0);
        check("5a_valid", rx_valid, 1);
        check("5a_data", rx_data, 8'h5A);
        check("5a_flags", {parity_err, frame_err}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
